// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard controller: forwarding select codes,
// memory-wait FSM states and the hard-wired zero register index.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      FAULT    = 2'b10
   } hz_state_t;

   localparam int REG_X0 = 0;

endpackage

// File: rtl/forward_select.sv
// Operand forwarding select for one Execute source register.
// Memory-stage result has priority over Writeback; x0 never forwards.
module forward_select
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_e,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic                  reg_write_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  reg_write_w,
   output fwd_sel_t              fwd_sel
);

   localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

   always_comb begin
      fwd_sel = FWD_RF;
      if (reg_write_m && (rd_m != X0) && (rd_m == rs_e)) begin
         fwd_sel = FWD_MEM;
      end else if (reg_write_w && (rd_w != X0) && (rd_w == rs_e)) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stall-flush, and a
// data-memory wait FSM with timeout watchdog. HAZARD_STATS_EN adds stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rs1_e,
   input  logic [REG_ADDR_W-1:0] rs2_e,
   input  logic [REG_ADDR_W-1:0] rd_e,
   input  logic                  load_e,
   input  logic                  pc_src_e,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic                  reg_write_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  reg_write_w,
   input  logic                  mem_req_m,
   input  logic                  mem_ready_m,
   output logic [1:0]            forward_a_e,
   output logic [1:0]            forward_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  stall_e,
   output logic                  stall_m,
   output logic                  stall_w,
   output logic                  flush_d,
   output logic                  flush_e,
`ifdef HAZARD_STATS_EN
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_count,
`endif
   output logic                  mem_timeout
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   hz_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   fwd_sel_t         fwd_a, fwd_b;
   logic             lu, mw;

   forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .rs_e        (rs1_e),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .fwd_sel     (fwd_a)
   );

   forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .rs_e        (rs2_e),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .fwd_sel     (fwd_b)
   );

   assign forward_a_e = rst ? FWD_RF : fwd_a;
   assign forward_b_e = rst ? FWD_RF : fwd_b;

   assign lu = load_e && (rd_e != X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
   assign mw = mem_req_m && !mem_ready_m && (state_q != FAULT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         RUN: begin
            if (mw) begin
               state_d = MEM_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready_m) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = FAULT;
               mem_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FAULT: begin
            mem_timeout_d = 1'b1;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // A memory wait freezes the whole pipe; load-use and redirect are re-evaluated once it releases.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      stall_w = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (!rst) begin
         if (mw) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
         end else begin
            stall_f = lu && !pc_src_e;
            stall_d = lu && !pc_src_e;
            flush_d = pc_src_e;
            flush_e = lu || pc_src_e;
         end
      end
   end

   assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall_f && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (flush_e && (flush_count_q != 32'hFFFF_FFFF)) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus randomized
// traffic against a behavioural model of forwarding, stalls and the memory watchdog.
module tb_hazard_ctrl;

   localparam int AW  = 5;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic          load_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m;
   logic [1:0]    forward_a_e, forward_b_e;
   logic          stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, mem_timeout;
`ifdef HAZARD_STATS_EN
   logic [31:0]   stall_cycles, flush_count;
`endif

   int checks   = 0;
   int failures = 0;

   // model state: consecutive memory-stall cycles and the sticky fault
   int m_run   = 0;
   bit m_fault = 1'b0;
   int m_stalls = 0;
   int m_flushes = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .rs1_d        (rs1_d),
      .rs2_d        (rs2_d),
      .rs1_e        (rs1_e),
      .rs2_e        (rs2_e),
      .rd_e         (rd_e),
      .load_e       (load_e),
      .pc_src_e     (pc_src_e),
      .rd_m         (rd_m),
      .reg_write_m  (reg_write_m),
      .rd_w         (rd_w),
      .reg_write_w  (reg_write_w),
      .mem_req_m    (mem_req_m),
      .mem_ready_m  (mem_ready_m),
      .forward_a_e  (forward_a_e),
      .forward_b_e  (forward_b_e),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .stall_e      (stall_e),
      .stall_m      (stall_m),
      .stall_w      (stall_w),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
`ifdef HAZARD_STATS_EN
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count),
`endif
      .mem_timeout  (mem_timeout)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] fwd_model(input logic [AW-1:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic clear_inputs();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      {load_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m} = '0;
   endtask

   // Called with inputs applied just after a negedge; checks outputs, clocks, returns at next negedge.
   task automatic step();
      logic       lu, mw;
      logic [6:0] ex;
      #1;
      if (rst) begin
         m_run = 0; m_fault = 1'b0; m_stalls = 0; m_flushes = 0;
      end
      lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      mw = mem_req_m && !mem_ready_m && !m_fault;
      if (rst)     ex = 7'b0;
      else if (mw) ex = 7'b1111100;
      else         ex = {lu && !pc_src_e, lu && !pc_src_e, 3'b000, pc_src_e, lu || pc_src_e};
      check_val("ctl", {25'b0, stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e}, {25'b0, ex});
      check_val("fwd_a", {30'b0, forward_a_e}, {30'b0, rst ? 2'b00 : fwd_model(rs1_e)});
      check_val("fwd_b", {30'b0, forward_b_e}, {30'b0, rst ? 2'b00 : fwd_model(rs2_e)});
      check_val("tmo", {31'b0, mem_timeout}, {31'b0, m_fault});
`ifdef HAZARD_STATS_EN
      check_val("stall_cycles", stall_cycles, m_stalls);
      check_val("flush_count", flush_count, m_flushes);
`endif
      @(posedge clk);
      if (!rst) begin
         if (ex[6]) m_stalls++;
         if (ex[0]) m_flushes++;
         if (!m_fault) begin
            if (mw) begin
               m_run++;
               if (m_run == TMO) m_fault = 1'b1;
            end else begin
               m_run = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      step();
      step();
      rst = 1'b0;

      // ALU dependency forwarding
      rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
      #1 check_val("alu_fwd_mem", {30'b0, forward_a_e}, 32'h2);
      step();
      reg_write_m = 0;
      #1 check_val("alu_fwd_wb", {30'b0, forward_a_e}, 32'h1);
      step();
      rd_m = 0; rd_w = 0; rs1_e = 0; reg_write_m = 1;
      #1 check_val("alu_fwd_x0", {30'b0, forward_a_e}, 32'h0);
      step();

      // load-use, then release, then rd_e=x0
      clear_inputs();
      load_e = 1; rd_e = 7; rs2_d = 7;
      #1 check_val("lu_stall", {28'b0, stall_f, stall_d, flush_e, flush_d}, 32'he);
      step();
      load_e = 0;
      #1 check_val("lu_release", {31'b0, stall_f}, 32'h0);
      step();
      load_e = 1; rd_e = 0; rs2_d = 0;
      #1 check_val("lu_x0", {31'b0, stall_f}, 32'h0);
      step();

      // branch taken coinciding with load-use
      load_e = 1; rd_e = 7; rs2_d = 7; pc_src_e = 1;
      #1 check_val("br_lu", {28'b0, stall_f, stall_d, flush_d, flush_e}, 32'h3);
      step();

      // memory wait of 3 cycles then ready
      clear_inputs();
      mem_req_m = 1;
      for (int i = 0; i < 3; i++) begin
         #1 check_val("mw_stall", {27'b0, stall_f, stall_d, stall_e, stall_m, stall_w}, 32'h1f);
         step();
      end
      mem_ready_m = 1;
      #1 check_val("mw_ready", {27'b0, stall_f, stall_d, stall_e, stall_m, stall_w}, 32'h0);
      step();
      mem_req_m = 0; mem_ready_m = 0;
      #1 check_val("mw_no_tmo", {31'b0, mem_timeout}, 32'h0);
      step();

      // watchdog timeout
      mem_req_m = 1;
      for (int i = 0; i < TMO; i++) begin
         #1 check_val("tmo_stall", {31'b0, stall_e}, 32'h1);
         step();
      end
      #1 check_val("fault_state", {30'b0, mem_timeout, stall_e}, 32'h2);
      step();
      rst = 1'b1;
      #1 check_val("fault_async_clr", {31'b0, mem_timeout}, 32'h0);
      step();
      rst = 1'b0;

      // reset during MEM_WAIT, then confirm the counter restarts from zero
      step();
      step();
      rst = 1'b1;
      #1 check_val("rst_in_wait", {31'b0, stall_f}, 32'h0);
      step();
      rst = 1'b0; mem_req_m = 0;
      step();
      mem_req_m = 1;
      for (int i = 0; i < TMO; i++) step();
      #1 check_val("post_rst_tmo", {31'b0, mem_timeout}, 32'h1);
      step();
      clear_inputs();
      reset_pulse();

      // randomized traffic with small register indices to force collisions
      for (int n = 0; n < 600; n++) begin
         rs1_d = AW'($urandom_range(0, 3));
         rs2_d = AW'($urandom_range(0, 3));
         rs1_e = AW'($urandom_range(0, 3));
         rs2_e = AW'($urandom_range(0, 3));
         rd_e  = AW'($urandom_range(0, 3));
         rd_m  = AW'($urandom_range(0, 3));
         rd_w  = AW'($urandom_range(0, 3));
         load_e      = ($urandom_range(0, 2) == 0);
         pc_src_e    = ($urandom_range(0, 3) == 0);
         reg_write_m = $urandom_range(0, 1);
         reg_write_w = $urandom_range(0, 1);
         mem_req_m   = (m_run > 0 && !m_fault) ? 1'b1 : ($urandom_range(0, 2) == 0);
         mem_ready_m = ($urandom_range(0, 3) == 0);
         rst         = (m_fault && $urandom_range(0, 3) == 0);
         step();
         rst = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
